// File: rtl/rb_pkg.sv
// rtl/rb_pkg.sv - shared widths, depths and late-result entry type for the writeback scheduler
package rb_pkg;

  localparam int REG_W       = 4;
  localparam int DATA_W      = 32;
  localparam int LFIFO_DEPTH = 2;
  localparam int STARVE_MAX  = 4;

  localparam int NUM_REGS = 1 << REG_W;
  localparam int LATE_W   = REG_W + DATA_W;
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  // One buffered late result: destination register and its data.
  typedef struct packed {
    logic [REG_W-1:0]  wc;
    logic [DATA_W-1:0] data;
  } late_t;

endpackage

// File: rtl/rb_fifo.sv
// rtl/rb_fifo.sv - small late-result FIFO with registered occupancy count
module rb_fifo
  import rb_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [LATE_W-1:0] push_data,
  input  logic              pop,
  output logic [LATE_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (LFIFO_DEPTH > 1) ? $clog2(LFIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(LFIFO_DEPTH + 1);

  logic [LATE_W-1:0] mem [LFIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  // Flags come straight from the registered count so ready never depends on this cycle's pop.
  assign full    = (count == CNT_W'(LFIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(LFIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Entry storage; contents are don't-care while unoccupied, so no reset.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and count; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rb_wsched.sv
// rtl/rb_wsched.sv - register-bank write scheduler merging pipeline and late results
module rb_wsched
  import rb_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              in_W_RB,
  input  logic [REG_W-1:0]  in_WC,
  input  logic [DATA_W-1:0] in_WPC,
  input  logic              in_L_valid,
  input  logic [REG_W-1:0]  in_L_WC,
  input  logic [DATA_W-1:0] in_L_data,
  output logic              out_L_ready,
  input  logic              in_issue_valid,
  input  logic [REG_W-1:0]  in_RA,
  input  logic [REG_W-1:0]  in_RB,
  input  logic [REG_W-1:0]  in_RD,
  input  logic              in_alloc,
  output logic              out_W_RB,
  output logic [REG_W-1:0]  out_WC,
  output logic [DATA_W-1:0] out_WD,
  output logic              out_stall,
  output logic              out_err
);

  logic [NUM_REGS-1:0] pending;
  logic [STARVE_W-1:0] starve_cnt;
  logic                fifo_full;
  logic                fifo_empty;
  logic [LATE_W-1:0]   head_flat;
  late_t               head;
  late_t               incoming;
  logic                fifo_push;
  logic                fifo_pop;
  logic                starved;
  logic                hazard;
  logic                alloc_fire;
  logic                l_blocked;
  logic                blk_prev;
  logic [LATE_W-1:0]   held_late;
  logic                err_now;

  assign incoming.wc   = in_L_WC;
  assign incoming.data = in_L_data;
  assign head          = head_flat;

  rb_fifo u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (incoming),
    .pop       (fifo_pop),
    .head      (head_flat),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // The pipeline always owns the port; the FIFO head only drains on idle cycles.
  // Draining is blocked during reset so buffered results are discarded, not written.
  assign out_L_ready = ~fifo_full;
  assign fifo_push   = in_L_valid & out_L_ready;
  assign fifo_pop    = ~fifo_empty & ~in_W_RB & ~reset;
  assign out_W_RB    = in_W_RB | fifo_pop;
  assign out_WC      = in_W_RB ? in_WC : head.wc;
  assign out_WD      = in_W_RB ? in_WPC : head.data;

  assign starved    = (starve_cnt == STARVE_W'(STARVE_MAX));
  assign hazard     = in_issue_valid & (pending[in_RA] | pending[in_RB] | pending[in_RD]);
  assign out_stall  = hazard | starved | (in_issue_valid & in_alloc & fifo_full);
  assign alloc_fire = in_issue_valid & in_alloc & ~out_stall;

  // A producer must hold its result steady once it has been refused for a cycle.
  assign l_blocked = in_L_valid & ~out_L_ready;
  assign err_now   = (fifo_push & ~pending[in_L_WC]) |
                     (blk_prev & l_blocked & (incoming != held_late));

  // Scoreboard: drain clears first so a same-cycle allocation of that register wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= '0;
    end else begin
      if (fifo_pop)   pending[head.wc] <= 1'b0;
      if (alloc_fire) pending[in_RD]   <= 1'b1;
    end
  end

  // Starvation counter: counts consecutive cycles the pipeline hogs the port over a waiting entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (~fifo_empty & in_W_RB) begin
      starve_cnt <= starved ? starve_cnt : starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  // Sticky protocol error plus the previous-cycle refusal history it needs.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_err   <= 1'b0;
      blk_prev  <= 1'b0;
      held_late <= '0;
    end else begin
      out_err   <= out_err | err_now;
      blk_prev  <= l_blocked;
      held_late <= incoming;
    end
  end

endmodule

// File: tb/tb_rb_wsched.sv
// tb/tb_rb_wsched.sv - randomized self-checking bench for rb_wsched against a queue-based model
module tb_rb_wsched;

  logic        clock;
  logic        reset;
  logic        in_W_RB;
  logic [3:0]  in_WC;
  logic [31:0] in_WPC;
  logic        in_L_valid;
  logic [3:0]  in_L_WC;
  logic [31:0] in_L_data;
  logic        out_L_ready;
  logic        in_issue_valid;
  logic [3:0]  in_RA;
  logic [3:0]  in_RB;
  logic [3:0]  in_RD;
  logic        in_alloc;
  logic        out_W_RB;
  logic [3:0]  out_WC;
  logic [31:0] out_WD;
  logic        out_stall;
  logic        out_err;

  rb_wsched dut (
    .clock          (clock),
    .reset          (reset),
    .in_W_RB        (in_W_RB),
    .in_WC          (in_WC),
    .in_WPC         (in_WPC),
    .in_L_valid     (in_L_valid),
    .in_L_WC        (in_L_WC),
    .in_L_data      (in_L_data),
    .out_L_ready    (out_L_ready),
    .in_issue_valid (in_issue_valid),
    .in_RA          (in_RA),
    .in_RB          (in_RB),
    .in_RD          (in_RD),
    .in_alloc       (in_alloc),
    .out_W_RB       (out_W_RB),
    .out_WC         (out_WC),
    .out_WD         (out_WD),
    .out_stall      (out_stall),
    .out_err        (out_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [3:0]  wc;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];
  bit          m_pend[16];
  int          m_starve;
  bit          m_err;
  bit          m_prev_blk;
  logic [35:0] m_prev_lat;
  bit          model_ok;

  int total;
  int bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_stall();
    bit haz;
    haz = in_issue_valid && (m_pend[in_RA] || m_pend[in_RB] || m_pend[in_RD]);
    return haz || (m_starve >= 4) || (in_issue_valid && in_alloc && m_q.size() == 2);
  endfunction

  // Compare all outputs against the model's view of the current cycle.
  task automatic settle();
    bit nonempty;
    bit exp_wrb;
    #1;
    if (model_ok) begin
      nonempty = (m_q.size() > 0);
      exp_wrb  = in_W_RB || (nonempty && !reset);
      chk("ready", out_L_ready, (m_q.size() < 2));
      chk("stall", out_stall, m_stall());
      chk("err", out_err, m_err);
      chk("w_rb", out_W_RB, exp_wrb);
      if (in_W_RB) begin
        chk("wc_pipe", out_WC, in_WC);
        chk("wd_pipe", out_WD, in_WPC);
      end else if (exp_wrb) begin
        chk("wc_late", out_WC, m_q[0].wc);
        chk("wd_late", out_WD, m_q[0].data);
      end
    end
  endtask

  // Step the model across the rising edge using the inputs that were applied.
  task automatic advance();
    bit nonempty, ready, blk, push, stall;
    @(posedge clock);
    if (reset) begin
      m_q.delete();
      foreach (m_pend[i]) m_pend[i] = 0;
      m_starve   = 0;
      m_err      = 0;
      m_prev_blk = 0;
      m_prev_lat = '0;
      model_ok   = 1;
    end else begin
      nonempty = (m_q.size() > 0);
      ready    = (m_q.size() < 2);
      stall    = m_stall();
      blk      = in_L_valid && !ready;
      push     = in_L_valid && ready;
      if (m_prev_blk && blk && ({in_L_WC, in_L_data} != m_prev_lat)) m_err = 1;
      if (push && !m_pend[in_L_WC]) m_err = 1;
      m_starve = (nonempty && in_W_RB) ? ((m_starve < 4) ? m_starve + 1 : 4) : 0;
      if (!in_W_RB && nonempty) begin
        m_pend[m_q[0].wc] = 0;
        void'(m_q.pop_front());
      end
      if (in_issue_valid && in_alloc && !stall) m_pend[in_RD] = 1;
      if (push) m_q.push_back('{wc: in_L_WC, data: in_L_data});
      m_prev_blk = blk;
      m_prev_lat = {in_L_WC, in_L_data};
    end
    @(negedge clock);
  endtask

  task automatic idle();
    reset = 0; in_W_RB = 0; in_WC = 0; in_WPC = 0;
    in_L_valid = 0; in_L_WC = 0; in_L_data = 0;
    in_issue_valid = 0; in_alloc = 0; in_RA = 0; in_RB = 0; in_RD = 0;
  endtask

  task automatic alloc_reg(input logic [3:0] r);
    idle();
    in_issue_valid = 1; in_alloc = 1; in_RD = r;
    settle(); advance();
  endtask

  task automatic do_reset();
    idle(); reset = 1;
    settle(); advance();
    idle();
  endtask

  initial begin
    total = 0; bad = 0; model_ok = 0;
    idle(); reset = 1;
    advance();
    idle();

    // Reset state
    settle();
    chk("rst_ready", out_L_ready, 1);
    chk("rst_stall", out_stall, 0);
    chk("rst_err", out_err, 0);
    in_W_RB = 1; in_WC = 4'hA; in_WPC = 32'h0BAD_F00D;
    settle();
    chk("rst_wrb", out_W_RB, 1);
    chk("rst_wd", out_WD, 32'h0BAD_F00D);
    advance();

    // Late result lands one cycle after acceptance and clears pending
    alloc_reg(5);
    idle(); in_L_valid = 1; in_L_WC = 5; in_L_data = 32'hDEAD_BEEF;
    settle();
    chk("no_bypass", out_W_RB, 0);
    advance();
    idle();
    settle();
    chk("late_wrb", out_W_RB, 1);
    chk("late_wc", out_WC, 5);
    chk("late_wd", out_WD, 32'hDEAD_BEEF);
    advance();
    in_issue_valid = 1; in_RA = 5;
    settle();
    chk("pend5_clear", out_stall, 0);
    advance();

    // RAW stall holds until the cycle after the bank write
    alloc_reg(5);
    idle(); in_issue_valid = 1; in_RA = 5;
    for (int i = 0; i < 2; i++) begin
      settle(); chk("raw_stall", out_stall, 1); advance();
    end
    in_L_valid = 1; in_L_WC = 5; in_L_data = 32'h5555_0005;
    settle(); chk("raw_stall_push", out_stall, 1); advance();
    in_L_valid = 0;
    settle(); chk("raw_wr_cycle_wrb", out_W_RB, 1); chk("raw_wr_cycle_stall", out_stall, 1); advance();
    settle(); chk("raw_release", out_stall, 0); advance();

    // Starvation: two pushes under a busy pipeline
    do_reset();
    alloc_reg(1);
    alloc_reg(2);
    idle(); in_W_RB = 1; in_WC = 7; in_WPC = 32'h7777_0000;
    in_L_valid = 1; in_L_WC = 1; in_L_data = 32'hA1A1_0001;
    settle(); chk("stv_ready0", out_L_ready, 1); advance();
    in_L_WC = 2; in_L_data = 32'hA2A2_0002;
    settle(); chk("stv_ready1", out_L_ready, 1); chk("stv_stall0", out_stall, 0); advance();
    in_L_valid = 0;
    for (int k = 1; k <= 5; k++) begin
      settle();
      chk("stv_stall", out_stall, (k >= 4));
      if (k == 1) chk("stv_full", out_L_ready, 0);
      advance();
    end
    in_W_RB = 0;
    settle(); chk("stv_drain_wc", out_WC, 1); chk("stv_drain_wd", out_WD, 32'hA1A1_0001);
    chk("stv_drain_stall", out_stall, 1); advance();
    settle(); chk("stv_released", out_stall, 0); chk("stv_ready_back", out_L_ready, 1);
    chk("stv_second_wc", out_WC, 2); advance();

    // Pipeline and late write in the same cycle with an empty FIFO
    alloc_reg(3);
    idle(); in_W_RB = 1; in_WC = 8; in_WPC = 32'h0000_1234;
    in_L_valid = 1; in_L_WC = 3; in_L_data = 32'hCAFE_0003;
    settle(); chk("coll_wc", out_WC, 8); chk("coll_wd", out_WD, 32'h0000_1234); advance();
    idle();
    settle(); chk("coll_late_wc", out_WC, 3); chk("coll_late_wd", out_WD, 32'hCAFE_0003); advance();

    // Reset discards two buffered entries
    alloc_reg(4);
    alloc_reg(6);
    idle(); in_W_RB = 1; in_L_valid = 1; in_L_WC = 4; in_L_data = 32'h4444_4444;
    settle(); advance();
    in_L_WC = 6; in_L_data = 32'h6666_6666;
    settle(); advance();
    idle(); reset = 1;
    settle(); chk("rst_no_drain", out_W_RB, 0); advance();
    idle(); in_issue_valid = 1; in_RA = 4; in_RB = 6;
    settle(); chk("post_rst_wrb", out_W_RB, 0); chk("post_rst_ready", out_L_ready, 1);
    chk("post_rst_sb", out_stall, 0); advance();

    // Late result to a register that is not pending
    idle(); in_L_valid = 1; in_L_WC = 9; in_L_data = 32'h9999_0009;
    settle(); advance();
    idle();
    for (int i = 0; i < 3; i++) begin
      settle(); chk("err_sticky", out_err, 1); advance();
    end
    do_reset();
    settle(); chk("err_cleared", out_err, 0); advance();

    // Randomized traffic checked every cycle against the model
    for (int n = 0; n < 4000; n++) begin
      bit hold;
      hold = in_L_valid && (m_q.size() == 2) && ($urandom_range(15) != 0) && !reset;
      reset          = ($urandom_range(199) == 0);
      in_W_RB        = $urandom_range(1);
      in_WC          = 4'($urandom);
      in_WPC         = $urandom;
      in_issue_valid = $urandom_range(1);
      in_alloc       = ($urandom_range(2) == 0);
      in_RA          = 4'($urandom);
      in_RB          = 4'($urandom);
      in_RD          = 4'($urandom);
      if (!hold) begin
        in_L_valid = ($urandom_range(2) == 0);
        in_L_WC    = 4'($urandom);
        in_L_data  = $urandom;
        if (!m_pend[in_L_WC] && $urandom_range(15) != 0) in_L_valid = 0;
      end
      settle();
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
